// File: rtl/alu_pkg.sv
// Shared ALU function codes, condition-code bit positions and CC reset value
// for the shared ALU scheduler and its datapath core.
package alu_pkg;
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   localparam logic [2:0] CC_RST = 3'b100;
endpackage

// File: rtl/alu_share_sched_if.sv
// Request/response bundle between two ALU requesters, the scheduler and the
// result consumer; slave is the scheduler side, master the pipeline side.
interface alu_share_sched_if #(
   parameter int W    = 64,
   parameter int NREQ = 2
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0][3:0]   req_fun;
   logic [NREQ-1:0][W-1:0] req_a;
   logic [NREQ-1:0][W-1:0] req_b;
   logic [NREQ-1:0]        req_setcc;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_id;
   logic [W-1:0]           rsp_val;
   logic [2:0]             rsp_cc;
   logic                   rsp_err;
   logic [2:0]             cc_out;

   modport slave (
      input  req_valid, req_fun, req_a, req_b, req_setcc, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_val, rsp_cc, rsp_err, cc_out
   );

   modport master (
      output req_valid, req_fun, req_a, req_b, req_setcc, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_val, rsp_cc, rsp_err, cc_out
   );
endinterface

// File: rtl/alu_core.sv
// Combinational Y86-64 integer ALU (add/sub/and/xor) with ZF/SF/OF; zero latency,
// no flow control. Illegal function codes return zero with err set and all flags clear.
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [3:0]   fun,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] val,
   output logic         zf,
   output logic         sf,
   output logic         of,
   output logic         err
);
   logic         is_sub;
   logic [W-1:0] a_op;
   logic [W-1:0] sum;

   // b - a is formed as b + ~a + 1, sharing the single adder with addq
   assign is_sub = (fun == ALU_SUB);
   assign a_op   = is_sub ? ~a : a;
   assign sum    = b + a_op + {{(W-1){1'b0}}, is_sub};

   always_comb begin
      val = '0;
      of  = 1'b0;
      err = 1'b0;
      case (fun)
         ALU_ADD, ALU_SUB: begin
            val = sum;
            of  = (a_op[W-1] == b[W-1]) && (sum[W-1] != b[W-1]);
         end
         ALU_AND: val = a & b;
         ALU_XOR: val = a ^ b;
         default: err = 1'b1;
      endcase
   end

   assign zf = !err && (val == '0);
   assign sf = val[W-1];
endmodule

// File: rtl/alu_share_sched.sv
// Round-robin share of one ALU between two requesters; result registered 1 cycle after accept.
// Buffer frees on same-cycle drain; while the result is stalled no request is granted.
module alu_share_sched
   import alu_pkg::*;
#(
   parameter int W    = 64,
   parameter int NREQ = 2
) (
   input logic              clk,
   input logic              rst,
   alu_share_sched_if.slave bus
);
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_id_q,    rsp_id_d;
   logic [W-1:0]    rsp_val_q,   rsp_val_d;
   logic [2:0]      rsp_cc_q,    rsp_cc_d;
   logic            rsp_err_q,   rsp_err_d;
   logic [2:0]      cc_q,        cc_d;
   logic            last_q,      last_d;

   logic            free;
   logic [NREQ-1:0] grant;
   logic            sel;
   logic [W-1:0]    core_val;
   logic            core_zf, core_sf, core_of, core_err;
   logic [2:0]      flags;

   assign free = !rsp_valid_q || bus.rsp_ready;

   // On contention the port that did not win last time goes next
   always_comb begin
      grant = '0;
      if (!rst && free) begin
         case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = '0;
         endcase
      end
   end

   assign sel = grant[1];

   alu_core #(.W(W)) u_core (
      .fun (bus.req_fun[sel]),
      .a   (bus.req_a[sel]),
      .b   (bus.req_b[sel]),
      .val (core_val),
      .zf  (core_zf),
      .sf  (core_sf),
      .of  (core_of),
      .err (core_err)
   );

   always_comb begin
      flags        = '0;
      flags[CC_ZF] = core_zf;
      flags[CC_SF] = core_sf;
      flags[CC_OF] = core_of;
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_val_d   = rsp_val_q;
      rsp_cc_d    = rsp_cc_q;
      rsp_err_d   = rsp_err_q;
      cc_d        = cc_q;
      last_d      = last_q;
      if (|grant) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = sel;
         rsp_val_d   = core_val;
         rsp_cc_d    = flags;
         rsp_err_d   = core_err;
         last_d      = sel;
         if (bus.req_setcc[sel] && !core_err) begin
            cc_d = flags;
         end
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_val_q   <= '0;
         rsp_cc_q    <= '0;
         rsp_err_q   <= 1'b0;
         cc_q        <= CC_RST;
         last_q      <= 1'b1;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_val_q   <= rsp_val_d;
         rsp_cc_q    <= rsp_cc_d;
         rsp_err_q   <= rsp_err_d;
         cc_q        <= cc_d;
         last_q      <= last_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_val   = rsp_val_q;
   assign bus.rsp_cc    = rsp_cc_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.cc_out    = cc_q;
endmodule

// File: tb/tb_alu_share_sched.sv
// Bench for the shared ALU scheduler: directed vectors, arbitration and stall
// sequences, then random traffic against a transaction-level reference model.
module tb_alu_share_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_share_sched_if #(.W(64), .NREQ(2)) bus ();

   alu_share_sched #(.W(64), .NREQ(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // reference state of the scheduler, tracked per transaction
   logic        m_valid, m_id, m_err, m_show;
   logic [63:0] m_val;
   logic [2:0]  m_cc, m_ccout;
   int          m_last;
   logic [1:0]  last_grant, pre_rdy;

   typedef struct {
      int          port;
      logic [3:0]  fun;
      logic [63:0] a;
      logic [63:0] b;
      logic        setcc;
      logic [63:0] exp_val;
      logic [2:0]  exp_cc;
      logic        exp_err;
      logic [2:0]  exp_ccout;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void alu_ref(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] v, output logic [2:0] cc, output logic e);
      logic signed [64:0] full;
      logic               of;
      full = '0;
      of   = 1'b0;
      e    = 1'b0;
      v    = '0;
      case (f)
         4'd0: begin
            full = $signed({b[63], b}) + $signed({a[63], a});
            v    = full[63:0];
            of   = (full != $signed({v[63], v}));
         end
         4'd1: begin
            full = $signed({b[63], b}) - $signed({a[63], a});
            v    = full[63:0];
            of   = (full != $signed({v[63], v}));
         end
         4'd2: v = a & b;
         4'd3: v = a ^ b;
         default: e = 1'b1;
      endcase
      cc = e ? 3'b000 : {(v == 64'd0), v[63], of};
   endfunction

   function automatic logic [1:0] exp_grant();
      if (rst) return 2'b00;
      if (m_valid && !bus.rsp_ready) return 2'b00;
      if (bus.req_valid == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
      return bus.req_valid;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_id    = 1'b0;
      m_val   = '0;
      m_cc    = '0;
      m_err   = 1'b0;
      m_ccout = 3'b100;
      m_last  = 1;
      m_show  = 1'b1;
   endtask

   // one clock: check grant before the edge, advance the model, check outputs after
   task automatic cycle();
      logic [1:0]  g;
      logic [63:0] v;
      logic [2:0]  c;
      logic        e;
      int          p;
      #1;
      g       = exp_grant();
      pre_rdy = bus.req_ready;
      chk("req_ready", {62'd0, bus.req_ready}, {62'd0, g});
      @(posedge clk);
      last_grant = g;
      if (rst) begin
         model_reset();
      end else if (g != 2'b00) begin
         p = g[1] ? 1 : 0;
         alu_ref(bus.req_fun[p], bus.req_a[p], bus.req_b[p], v, c, e);
         m_valid = 1'b1;
         m_id    = g[1];
         m_val   = v;
         m_cc    = c;
         m_err   = e;
         m_last  = p;
         if (bus.req_setcc[p] && !e) m_ccout = c;
         m_show  = 1'b1;
      end else begin
         if (bus.rsp_ready) m_valid = 1'b0;
         m_show = m_valid;
      end
      #1;
      chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, m_valid});
      chk("cc_out", {61'd0, bus.cc_out}, {61'd0, m_ccout});
      if (m_show) begin
         chk("rsp_id", {63'd0, bus.rsp_id}, {63'd0, m_id});
         chk("rsp_val", bus.rsp_val, m_val);
         chk("rsp_cc", {61'd0, bus.rsp_cc}, {61'd0, m_cc});
         chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, m_err});
      end
   endtask

   task automatic drive(input int p, input logic [3:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic s);
      bus.req_fun[p]   = f;
      bus.req_a[p]     = a;
      bus.req_b[p]     = b;
      bus.req_setcc[p] = s;
   endtask

   function automatic logic [63:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return 64'd1;
         2:       return 64'hFFFF_FFFF_FFFF_FFFF;
         3:       return 64'h8000_0000_0000_0000;
         4:       return 64'h7FFF_FFFF_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [1:0] exp_seq[4];
      logic       pend[2];

      vecs[0] = '{0, 4'h1, 64'd5, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 1'b0, 3'b010};
      vecs[1] = '{1, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFE, 3'b011, 1'b0, 3'b010};
      vecs[2] = '{0, 4'h7, 64'd1, 64'd1, 1'b1, 64'd0, 3'b000, 1'b1, 3'b010};
      vecs[3] = '{1, 4'h2, 64'hF0, 64'h0F, 1'b1, 64'd0, 3'b100, 1'b0, 3'b100};
      vecs[4] = '{0, 4'h3, 64'hFF, 64'hFF00, 1'b1, 64'hFFFF, 3'b000, 1'b0, 3'b000};
      vecs[5] = '{1, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 3'b100, 1'b0, 3'b100};
      vecs[6] = '{0, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 1'b1,
                  64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, 3'b001};
      vecs[7] = '{1, 4'h1, 64'h8000_0000_0000_0000, 64'd0, 1'b1,
                  64'h8000_0000_0000_0000, 3'b011, 1'b0, 3'b011};

      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      drive(0, 4'h0, 64'd1, 64'd1, 1'b1);
      drive(1, 4'h0, 64'd2, 64'd2, 1'b1);
      model_reset();

      // reset with both requesters valid: nothing granted, reset state visible
      rst = 1'b1;
      cycle();
      cycle();
      chk("reset rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      chk("reset cc_out", {61'd0, bus.cc_out}, 64'd4);
      rst = 1'b0;
      bus.req_valid = 2'b00;

      // directed single-port vectors
      for (int i = 0; i < 8; i++) begin
         bus.req_valid = (vecs[i].port == 0) ? 2'b01 : 2'b10;
         drive(vecs[i].port, vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].setcc);
         cycle();
         chk($sformatf("vec%0d rsp_val", i), bus.rsp_val, vecs[i].exp_val);
         chk($sformatf("vec%0d rsp_cc", i), {61'd0, bus.rsp_cc}, {61'd0, vecs[i].exp_cc});
         chk($sformatf("vec%0d rsp_err", i), {63'd0, bus.rsp_err}, {63'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d cc_out", i), {61'd0, bus.cc_out}, {61'd0, vecs[i].exp_ccout});
         chk($sformatf("vec%0d rsp_id", i), {63'd0, bus.rsp_id}, 64'(vecs[i].port));
      end

      // both valid, full drain: alternating grants starting at port 0
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
      bus.req_valid = 2'b11;
      drive(0, 4'h0, 64'd10, 64'd20, 1'b0);
      drive(1, 4'h1, 64'd3, 64'd30, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("alt%0d grant", i), {62'd0, pre_rdy}, {62'd0, exp_seq[i]});
         chk($sformatf("alt%0d rsp_id", i), {63'd0, bus.rsp_id}, 64'(i % 2));
      end

      // stalled consumer: no grants, result held; release grants port 0 at once
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk($sformatf("stall%0d grant", i), {62'd0, pre_rdy}, 64'd0);
         chk($sformatf("stall%0d rsp_val", i), bus.rsp_val, 64'd27);
      end
      bus.rsp_ready = 1'b1;
      cycle();
      chk("release grant", {62'd0, pre_rdy}, 64'd1);
      chk("release rsp_val", bus.rsp_val, 64'd30);

      // random traffic; requesters hold their request until granted
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && ($urandom_range(0, 9) < 6)) begin
               pend[p] = 1'b1;
               drive(p, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
                     rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            end
         end
         bus.req_valid = {pend[1], pend[0]};
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
         if (last_grant[0]) pend[0] = 1'b0;
         if (last_grant[1]) pend[1] = 1'b0;
      end

      // reset while a result is stalled
      bus.rsp_ready = 1'b1;
      bus.req_valid = 2'b01;
      drive(0, 4'h0, 64'd1, 64'd2, 1'b1);
      cycle();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 2'b11;
      cycle();
      rst = 1'b1;
      cycle();
      chk("mid rst rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      chk("mid rst cc_out", {61'd0, bus.cc_out}, 64'd4);
      chk("mid rst grant", {62'd0, pre_rdy}, 64'd0);
      rst = 1'b0;
      cycle();
      chk("post rst grant", {62'd0, pre_rdy}, 64'd1);
      chk("post rst rsp_id", {63'd0, bus.rsp_id}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
